hazard_scoreboard: RTL and testbench

Parametrised pipeline hazard and forwarding controller for the ARM core. It replaces the separate hazard-detection and forwarding units with one block. The block tracks every in-flight instruction from EXE to WB in its own shadow pipeline, supports a variable-latency memory stage by holding that shadow pipeline, and emits the ID stall and the EXE forwarding selects. It sits beside the ID/EXE boundary, fed by decode and by the pipeline-advance signal from the memory interface.

---
 rtl/arm_pipe_pkg.sv | 34 +++
 rtl/sb_fwd_select.sv | 26 ++
 rtl/hazard_scoreboard.sv | 124 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// arm_pipe_pkg: shared types and stage indices for the hazard scoreboard.
// Register indices are stored at REG_W_MAX bits so one entry type serves every REG_W <= REG_W_MAX.
package arm_pipe_pkg;

    localparam int REG_W_DEFAULT = 4;
    localparam int REG_W_MAX     = 8;
    localparam int DEPTH_DEFAULT = 3;

    localparam int STG_EXE = 0;
    localparam int STG_MEM = 1;

    typedef logic [REG_W_MAX-1:0] reg_idx_t;

    typedef struct packed {
        logic     v;
        reg_idx_t dest;
        logic     wb_en;
        logic     load;
        reg_idx_t s1;
        logic     s1v;
        reg_idx_t s2;
        logic     s2v;
    } sb_entry_t;

    // WB is the last tracked stage, so its index follows the configured depth.
    function automatic int stg_wb(input int depth);
        return depth - 1;
    endfunction

    function automatic logic stage_hit(input sb_entry_t e, input reg_idx_t src, input logic src_v);
        return e.v && e.wb_en && src_v && (e.dest == src);
    endfunction

endpackage

// File: rtl/sb_fwd_select.sv
// sb_fwd_select: priority matcher over shadow stages MEM..WB for one EXE source operand.
module sb_fwd_select
    import arm_pipe_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  sb_entry_t        i_stages [DEPTH],
    input  logic             i_en,
    input  reg_idx_t         i_src,
    input  logic             i_src_v,
    output logic [SEL_W-1:0] o_sel
);

    always_comb begin
        // NOTE: default assignment first so no path through the loop can infer a latch.
        o_sel = '0;
        // Walk oldest to youngest so the youngest forwardable producer is written last.
        for (int k = DEPTH - 1; k >= STG_MEM; k--) begin
            if (i_en && stage_hit(i_stages[k], i_src, i_src_v) &&
                !(i_stages[k].load && k < stg_wb(DEPTH)))
                o_sel = SEL_W'(k);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shadow EXE..WB pipeline driving the ID stall and EXE forwarding selects.
// Define SB_PERF_CNT_EN to add the saturating stall/issue performance counters and their ports.
module hazard_scoreboard
    import arm_pipe_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int SEL_W = $clog2(DEPTH),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forwarding_en,
    input  logic             pipe_adv,
    input  logic             flush,
    input  logic             iss_valid,
    input  logic [REG_W-1:0] iss_src1,
    input  logic [REG_W-1:0] iss_src2,
    input  logic             iss_two_src,
    input  logic             iss_ignore,
    input  logic [REG_W-1:0] iss_dest,
    input  logic             iss_wb_en,
    input  logic             iss_load,
    output logic             hazard,
    output logic [SEL_W-1:0] fwd_sel_src1,
    output logic [SEL_W-1:0] fwd_sel_src2
`ifdef SB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] issue_cnt
`endif
);

    sb_entry_t r_stage [DEPTH];
    sb_entry_t w_new;
    logic      w_hazard;
    logic      w_issue;

    always_comb begin
        w_new       = '0;
        w_new.v     = 1'b1;
        w_new.dest  = reg_idx_t'(iss_dest);
        w_new.wb_en = iss_wb_en;
        w_new.load  = iss_load;
        w_new.s1    = reg_idx_t'(iss_src1);
        w_new.s1v   = !iss_ignore;
        w_new.s2    = reg_idx_t'(iss_src2);
        w_new.s2v   = !iss_ignore && iss_two_src;
    end

    // With forwarding only a load still in EXE blocks; otherwise anything short of WB does,
    // because the register file writes on the falling edge.
    always_comb begin
        w_hazard = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (stage_hit(r_stage[k], w_new.s1, w_new.s1v) ||
                stage_hit(r_stage[k], w_new.s2, w_new.s2v)) begin
                if (!forwarding_en || (k == STG_EXE && r_stage[k].load))
                    w_hazard = 1'b1;
            end
        end
        w_hazard = w_hazard && iss_valid && !iss_ignore;
    end

    assign hazard  = w_hazard;
    assign w_issue = iss_valid && !w_hazard && !flush && pipe_adv;

    // NOTE: the shadow stages are a handful of flops, so every entry is cleared on reset,
    // which drops all in-flight instructions the moment rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++)
                r_stage[k] <= '0;
        end else if (pipe_adv) begin
            // NOTE: non-blocking updates let every stage read its neighbour's old value.
            r_stage[STG_EXE] <= w_issue ? w_new : '0;
            for (int k = 1; k < DEPTH; k++)
                r_stage[k] <= r_stage[k-1];
        end
    end

    sb_fwd_select #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) u_fwd_src1 (
        .i_stages (r_stage),
        .i_en     (forwarding_en),
        .i_src    (r_stage[STG_EXE].s1),
        .i_src_v  (r_stage[STG_EXE].v && r_stage[STG_EXE].s1v),
        .o_sel    (fwd_sel_src1)
    );

    sb_fwd_select #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) u_fwd_src2 (
        .i_stages (r_stage),
        .i_en     (forwarding_en),
        .i_src    (r_stage[STG_EXE].s2),
        .i_src_v  (r_stage[STG_EXE].v && r_stage[STG_EXE].s2v),
        .o_sel    (fwd_sel_src2)
    );

`ifdef SB_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_issue_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_issue_cnt <= '0;
        end else begin
            if (pipe_adv && iss_valid && w_hazard && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_issue && r_issue_cnt != '1)
                r_issue_cnt <= r_issue_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign issue_cnt = r_issue_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and random stimulus against an in-flight-list reference model.
// Counter checks are compiled in when SB_PERF_CNT_EN is defined.
module tb_hazard_scoreboard;

    localparam int REG_W   = 4;
    localparam int DEPTH   = 3;
    localparam int SEL_W   = $clog2(DEPTH);
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             forwarding_en;
    logic             pipe_adv;
    logic             flush;
    logic             iss_valid;
    logic [REG_W-1:0] iss_src1;
    logic [REG_W-1:0] iss_src2;
    logic             iss_two_src;
    logic             iss_ignore;
    logic [REG_W-1:0] iss_dest;
    logic             iss_wb_en;
    logic             iss_load;
    logic             hazard;
    logic [SEL_W-1:0] fwd_sel_src1;
    logic [SEL_W-1:0] fwd_sel_src2;
`ifdef SB_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] issue_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_W (REG_W),
        .DEPTH (DEPTH),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .forwarding_en (forwarding_en),
        .pipe_adv      (pipe_adv),
        .flush         (flush),
        .iss_valid     (iss_valid),
        .iss_src1      (iss_src1),
        .iss_src2      (iss_src2),
        .iss_two_src   (iss_two_src),
        .iss_ignore    (iss_ignore),
        .iss_dest      (iss_dest),
        .iss_wb_en     (iss_wb_en),
        .iss_load      (iss_load),
        .hazard        (hazard),
        .fwd_sel_src1  (fwd_sel_src1),
        .fwd_sel_src2  (fwd_sel_src2)
`ifdef SB_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt),
        .issue_cnt     (issue_cnt)
`endif
    );

    // Reference model: the list of issued instructions still in flight, each tagged with
    // how many pipeline advances it has seen (0 = EXE, DEPTH-1 = WB).
    typedef struct {
        int dest;
        bit wb;
        bit load;
        int s1;
        int s2;
        bit two;
        bit ign;
        int stg;
    } minst_t;

    minst_t flight[$];
    int     m_stall = 0;
    int     m_issue = 0;

    function automatic bit writes_to(input minst_t f, input int r);
        return f.wb && (f.dest == r);
    endfunction

    function automatic bit m_hazard();
        bit hz = 0;
        if (!iss_valid || iss_ignore)
            return 0;
        foreach (flight[i]) begin
            bit hit;
            hit = writes_to(flight[i], int'(iss_src1)) ||
                  (iss_two_src && writes_to(flight[i], int'(iss_src2)));
            if (hit) begin
                if (forwarding_en) begin
                    if (flight[i].stg == 0 && flight[i].load)
                        hz = 1;
                end else if (flight[i].stg <= DEPTH - 2) begin
                    hz = 1;
                end
            end
        end
        return hz;
    endfunction

    function automatic int m_fwd(input bit second);
        int exe_i = -1;
        int best  = 0;
        int src;
        bit srcv;
        if (!forwarding_en)
            return 0;
        foreach (flight[i])
            if (flight[i].stg == 0)
                exe_i = i;
        if (exe_i < 0)
            return 0;
        src  = second ? flight[exe_i].s2 : flight[exe_i].s1;
        srcv = !flight[exe_i].ign && (!second || flight[exe_i].two);
        if (!srcv)
            return 0;
        foreach (flight[i]) begin
            if (flight[i].stg >= 1 && writes_to(flight[i], src) &&
                !(flight[i].load && flight[i].stg < DEPTH - 1) &&
                (best == 0 || flight[i].stg < best))
                best = flight[i].stg;
        end
        return best;
    endfunction

    function automatic void m_tick();
        bit     hz;
        minst_t n;
        hz = m_hazard();
        if (pipe_adv) begin
            if (iss_valid && hz && m_stall < CNT_MAX)
                m_stall++;
            foreach (flight[i])
                flight[i].stg++;
            while (flight.size() > 0 && flight[0].stg >= DEPTH)
                void'(flight.pop_front());
            if (iss_valid && !hz && !flush) begin
                n.dest = int'(iss_dest);
                n.wb   = iss_wb_en;
                n.load = iss_load;
                n.s1   = int'(iss_src1);
                n.s2   = int'(iss_src2);
                n.two  = iss_two_src;
                n.ign  = iss_ignore;
                n.stg  = 0;
                flight.push_back(n);
                if (m_issue < CNT_MAX)
                    m_issue++;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic present(input bit v, input int d, input int a, input int b,
                           input bit two, input bit wb, input bit ld, input bit ign = 0);
        iss_valid   = v;
        iss_dest    = REG_W'(d);
        iss_src1    = REG_W'(a);
        iss_src2    = REG_W'(b);
        iss_two_src = two;
        iss_wb_en   = wb;
        iss_load    = ld;
        iss_ignore  = ign;
    endtask

    task automatic idle();
        present(0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: compare against the model mid-cycle, then advance the model on the edge.
    // A directed expectation of -1 means only the model comparison applies.
    task automatic cyc(input string tag, input int e_hz, input int e_f1, input int e_f2);
        @(negedge clk);
        check({tag, ".hazard"}, 32'(hazard), 32'(m_hazard()));
        check({tag, ".fwd1"}, 32'(fwd_sel_src1), 32'(m_fwd(0)));
        check({tag, ".fwd2"}, 32'(fwd_sel_src2), 32'(m_fwd(1)));
        if (e_hz >= 0) check({tag, ".hazard_dir"}, 32'(hazard), 32'(e_hz));
        if (e_f1 >= 0) check({tag, ".fwd1_dir"}, 32'(fwd_sel_src1), 32'(e_f1));
        if (e_f2 >= 0) check({tag, ".fwd2_dir"}, 32'(fwd_sel_src2), 32'(e_f2));
`ifdef SB_PERF_CNT_EN
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        check({tag, ".issue_cnt"}, 32'(issue_cnt), 32'(m_issue));
`endif
        @(posedge clk);
        m_tick();
        #1;
    endtask

    task automatic drain();
        idle();
        flush = 0;
        pipe_adv = 1;
        repeat (DEPTH) cyc("drain", -1, -1, -1);
    endtask

    initial begin
        int exp_issue;

        rst = 0;
        forwarding_en = 1;
        pipe_adv = 1;
        flush = 0;
        idle();
        #12;
        check("reset.hazard", 32'(hazard), 0);
        check("reset.fwd1", 32'(fwd_sel_src1), 0);
        check("reset.fwd2", 32'(fwd_sel_src2), 0);
`ifdef SB_PERF_CNT_EN
        check("reset.stall_cnt", 32'(stall_cnt), 0);
        check("reset.issue_cnt", 32'(issue_cnt), 0);
`endif
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;

        // Back-to-back dependency with forwarding: ADD r1,r2,r3 ; SUB r2,r1,r3.
        forwarding_en = 1;
        present(1, 1, 2, 3, 1, 1, 0); cyc("b2b_fwd.add", 0, 0, 0);
        present(1, 2, 1, 3, 1, 1, 0); cyc("b2b_fwd.sub", 0, 0, 0);
        idle();                       cyc("b2b_fwd.exe", 0, 1, 0);
        drain();

        // Same stream without forwarding: two stall cycles, then issue with selects at 0.
        forwarding_en = 0;
        present(1, 1, 2, 3, 1, 1, 0); cyc("nofwd.add", 0, 0, 0);
        present(1, 2, 1, 3, 1, 1, 0); cyc("nofwd.stall1", 1, 0, 0);
                                      cyc("nofwd.stall2", 1, 0, 0);
                                      cyc("nofwd.issue", 0, 0, 0);
        idle();                       cyc("nofwd.exe", 0, 0, 0);
        drain();

        // Load-use with a three-cycle memory wait: LDR r4,[r0] ; ADD r5,r4,r4.
        forwarding_en = 1;
        present(1, 4, 0, 0, 0, 1, 1); cyc("ldu.ldr", 0, 0, 0);
        pipe_adv = 0;
        present(1, 5, 4, 4, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc("ldu.wait", 1, 0, 0);
        pipe_adv = 1;
        cyc("ldu.last_stall", 1, 0, 0);
        cyc("ldu.issue", 0, 0, 0);
        idle();
        cyc("ldu.exe", 0, 2, 2);
        drain();

        // Youngest producer wins: two writers of r7, then a reader of r7 on both sources.
        present(1, 7, 0, 0, 0, 1, 0);  cyc("young.w1", 0, 0, 0);
        present(1, 7, 0, 0, 0, 1, 0);  cyc("young.w2", 0, 0, 0);
        present(1, 11, 7, 7, 1, 1, 0); cyc("young.rd", 0, 0, 0);
        idle();                        cyc("young.exe", 0, 1, 1);
        drain();

        // Flush over hazard: load-use hit with flush high inserts a bubble and issues nothing.
        present(1, 6, 0, 0, 0, 1, 1); cyc("flush.ldr", 0, 0, 0);
        exp_issue = m_issue;
        flush = 1;
        present(1, 8, 6, 6, 1, 1, 0); cyc("flush.hz", 1, -1, -1);
        flush = 0;
        forwarding_en = 0;
        present(1, 9, 8, 8, 1, 0, 0); cyc("flush.no_dep", 0, 0, 0);
`ifdef SB_PERF_CNT_EN
        check("flush.issue_cnt", 32'(issue_cnt), 32'(exp_issue + 1));
`endif
        drain();

        // A branch reading no registers never stalls, even on a live producer.
        present(1, 10, 0, 0, 0, 1, 0);        cyc("branch.w", 0, 0, 0);
        present(1, 0, 10, 10, 1, 0, 0, 1'b1); cyc("branch.ign", 0, 0, 0);
        drain();

        // Randomised traffic on a small register set so producers and consumers collide.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) forwarding_en = $urandom_range(0, 1);
            pipe_adv = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 9) == 0);
            present($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 1) != 0, $urandom_range(0, 4) != 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            cyc("rnd", -1, -1, -1);
        end
        drain();

        // Reset with three entries in flight (r1 <- r0, r2 <- r1, LDR r3 <- [r2]).
        forwarding_en = 1;
        present(1, 1, 0, 0, 0, 1, 0); cyc("rst.i1", 0, 0, 0);
        present(1, 2, 1, 0, 0, 1, 0); cyc("rst.i2", 0, 0, 0);
        present(1, 3, 2, 0, 0, 1, 1); cyc("rst.i3", 0, 1, 0);
        present(1, 4, 3, 3, 1, 1, 0);
        @(negedge clk);
        check("rst.pre_hazard", 32'(hazard), 1);
        check("rst.pre_fwd1", 32'(fwd_sel_src1), 1);
        #2;
        rst = 0;
        #1;
        check("rst.async_hazard", 32'(hazard), 0);
        check("rst.async_fwd1", 32'(fwd_sel_src1), 0);
        check("rst.async_fwd2", 32'(fwd_sel_src2), 0);
`ifdef SB_PERF_CNT_EN
        check("rst.async_stall_cnt", 32'(stall_cnt), 0);
        check("rst.async_issue_cnt", 32'(issue_cnt), 0);
`endif
        flight.delete();
        m_stall = 0;
        m_issue = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        forwarding_en = 0;
        present(1, 5, 1, 3, 1, 0, 0); cyc("rst.after", 0, 0, 0);

        // Twenty stall cycles without forwarding: the 4-bit counters stop at 15.
        for (int i = 0; i < 10; i++) begin
            present(1, 1, 0, 0, 0, 1, 0); cyc("sat.w", 0, -1, -1);
            present(1, 2, 1, 1, 1, 1, 0);
            cyc("sat.s1", 1, -1, -1);
            cyc("sat.s2", 1, -1, -1);
            cyc("sat.iss", 0, -1, -1);
        end
        idle();
        @(negedge clk);
`ifdef SB_PERF_CNT_EN
        check("sat.stall_cnt", 32'(stall_cnt), 15);
        check("sat.issue_cnt", 32'(issue_cnt), 15);
`endif
        check("sat.idle_hazard", 32'(hazard), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
